lc3b_mem_unit: RTL and testbench
================================

// Module: lc3b_mem_unit
// PURPOSE
//  Parametrised memory-access unit: next generation of the MAR/MDR/Memory path.
//  Accepts one load/store request per transaction from the controller and drives a variable-latency memory bus (req/ack).
//  Adds byte-lane steering, sign/zero extension, misalignment trapping and an optional bus timeout.
//  Sits between controller_lsb/datapath and the memory model.
// PARAMETERS
//  DATA_W    16  data bus width; 16 or 32 only; LANES = DATA_W/8
//  ADDR_W    16  byte address width
//  MAX_WAIT  15  bus cycles without ack before timeout; used only with MEM_UNIT_TIMEOUT_EN
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-low; 0 = in reset
//  req_valid  in   1          controller request present
//  req_ready  out  1          unit can accept; high only in IDLE
//  req_write  in   1          1 = store, 0 = load
//  req_size   in   1          0 = byte, 1 = full word
//  req_sext   in   1          byte load: 1 = sign-extend, 0 = zero-extend
//  req_addr   in   ADDR_W     byte address
//  req_wdata  in   DATA_W     store data; byte store uses [7:0]
//  rsp_valid  out  1          one-cycle pulse: transaction complete
//  rsp_rdata  out  DATA_W     load result; 0 for stores and errors
//  rsp_err    out  1          qualifies rsp_valid: misaligned or timeout
//  mem_req    out  1          bus request; held until mem_ack
//  mem_we     out  1          bus write
//  mem_be     out  LANES      byte enables
//  mem_addr   out  ADDR_W     word-aligned address (low log2(LANES) bits zero)
//  mem_wdata  out  DATA_W     bus write data
//  mem_rdata  in   DATA_W     bus read data, valid when mem_ack=1
//  mem_ack    in   1          bus completion; may arrive same cycle as mem_req
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; wait counter=0.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  IDLE: on req_valid&&req_ready, register request fields.
//   - Misaligned (word with addr[log2(LANES)-1:0]!=0) -> RESP, err=1; mem_req never asserted.
//   - Otherwise -> BUS.
//  BUS: mem_req=1; mem_we/mem_be/mem_addr/mem_wdata stable until mem_ack.
//   - On mem_ack: capture lane-steered read data -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle -> IDLE; req_ready=0 during BUS and RESP.
//  Latency: accept cycle T; mem_req from T+1; zero-wait ack at T+1 gives rsp_valid at T+2. Misaligned: rsp_valid at T+1.
//  Lanes: lane = addr[log2(LANES)-1:0].
//   - Byte access: mem_be = one-hot(lane); store replicates wdata[7:0] to every lane.
//   - Byte load: selects mem_rdata[8*lane+:8], then extends to DATA_W per req_sext.
//   - Word access: mem_be = all ones; data passes through unchanged.
//  Request inputs are ignored outside IDLE; back-to-back accept is possible the cycle after RESP.
//  Reset mid-transaction: all outputs return to reset values asynchronously; no response is issued for the aborted request.
// CONFIGURATION
//  MEM_UNIT_TIMEOUT_EN defined: BUS counts cycles without ack.
//   - Count reaching MAX_WAIT -> drop mem_req, go to RESP with rsp_err=1, rsp_rdata=0.
//   - Ack in the same cycle as timeout wins (normal completion).
//  Undefined: no counter is built; BUS waits for ack indefinitely.
// STRUCTURE
//  Package lc3b_mem_pkg: state enum (IDLE/BUS/RESP), SIZE_BYTE=1'b0, SIZE_WORD=1'b1.
//  Sub-module lc3b_byte_lane: combinational lane select, replication and extension, parametrised on DATA_W; one instance each for read and write steering.
// TESTING
//  1. Word load 0x3000, ack after 2 wait cycles, mem_rdata=0x1234 -> mem_be=2'b11, mem_addr=0x3000, rsp_rdata=0x1234, err=0.
//  2. Byte load sext 0x3001, mem_rdata=0x80FF -> mem_be=2'b10, rsp_rdata=0xFF80; with sext=0 -> 0x0080.
//  3. Byte store 0x3003, wdata=0x00AB -> mem_we=1, mem_be=2'b10, mem_addr=0x3002, mem_wdata=0xABAB, rsp_rdata=0.
//  4. Word load 0x3001 -> no mem_req, rsp_valid at T+1 with rsp_err=1.
//  5. reset=0 during BUS -> mem_req=0 immediately, no rsp_valid; next request completes normally.
//  6. With MEM_UNIT_TIMEOUT_EN, MAX_WAIT=15, ack held low -> mem_req drops after 15 BUS cycles, rsp_err=1.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared types for the LC-3b memory-access unit: FSM state encoding and access-size codes.
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/lc3b_byte_lane.sv
// Combinational byte-lane steering. WRITE=1 replicates the low byte across all lanes;
// WRITE=0 selects one lane and sign/zero-extends it. Full-word accesses pass through.
module lc3b_byte_lane
  import lc3b_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANE_W = $clog2(DATA_W / 8),
  parameter bit WRITE  = 1'b0
) (
  input  logic [LANE_W-1:0] lane,
  input  logic              size,
  input  logic              sext,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int LANES = DATA_W / 8;

  logic [7:0]        lane_byte;
  logic [DATA_W-1:0] extended;
  logic [DATA_W-1:0] replicated;

  assign lane_byte = data_in[8*lane +: 8];
  assign extended  = {{(DATA_W-8){sext & lane_byte[7]}}, lane_byte};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rep
    assign replicated[8*gi +: 8] = data_in[7:0];
  end

  assign data_out = (size == SIZE_BYTE) ? (WRITE ? replicated : extended) : data_in;

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory-access unit: one load/store per transaction over a req/ack bus with lane steering.
// Optional bus timeout is built when MEM_UNIT_TIMEOUT_EN is defined.
module lc3b_mem_unit
  import lc3b_mem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_size,
  input  logic                  req_sext,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  // Unsupported parameter sets never accept a request.
  localparam bit CFG_OK = ((DATA_W == 16) || (DATA_W == 32)) && (MAX_WAIT > 0);

  mem_state_t        state_reg;
  logic              write_reg;
  logic              size_reg;
  logic              sext_reg;
  logic [LANE_W-1:0] lane_reg;

  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [LANES-1:0]  mem_be_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic [LANE_W-1:0] req_lane;
  logic [LANES-1:0]  be_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] rdata_next;
  logic              accept;
  logic              misaligned;

`ifdef MEM_UNIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt_reg;
`endif

  assign req_lane   = req_addr[LANE_W-1:0];
  assign req_ready  = CFG_OK && (state_reg == IDLE);
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_size == SIZE_WORD) && (req_lane != '0);
  assign addr_next  = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_be
    assign be_next[gi] = (req_size == SIZE_WORD) || (req_lane == LANE_W'(gi));
  end

  lc3b_byte_lane #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .WRITE  (1'b1)
  ) u_wr_lane (
    .lane     (req_lane),
    .size     (req_size),
    .sext     (1'b0),
    .data_in  (req_wdata),
    .data_out (wdata_next)
  );

  lc3b_byte_lane #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .WRITE  (1'b0)
  ) u_rd_lane (
    .lane     (lane_reg),
    .size     (size_reg),
    .sext     (sext_reg),
    .data_in  (mem_rdata),
    .data_out (rdata_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      size_reg      <= SIZE_BYTE;
      sext_reg      <= 1'b0;
      lane_reg      <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
`ifdef MEM_UNIT_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg <= req_write;
            size_reg  <= req_size;
            sext_reg  <= req_sext;
            lane_reg  <= req_lane;
            if (misaligned) begin
              // Trap without touching the bus.
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              state_reg     <= BUS;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= req_write;
              mem_be_reg    <= be_next;
              mem_addr_reg  <= addr_next;
              mem_wdata_reg <= wdata_next;
`ifdef MEM_UNIT_TIMEOUT_EN
              wait_cnt_reg  <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            state_reg     <= RESP;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= '0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= write_reg ? '0 : rdata_next;
          end
`ifdef MEM_UNIT_TIMEOUT_EN
          // An ack arriving in the expiry cycle takes priority over the timeout.
          else if (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)) begin
            state_reg     <= RESP;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= '0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
            wait_cnt_reg  <= '0;
          end else begin
            wait_cnt_reg  <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        RESP: begin
          state_reg     <= IDLE;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Scoreboard bench for lc3b_mem_unit: byte-addressed reference memory, randomized bus latency,
// directed lane/misalignment/reset cases and, with MEM_UNIT_TIMEOUT_EN, the bus timeout.
`timescale 1ns/1ps
module tb_lc3b_mem_unit;

  localparam int MAX_WAIT = 15;
  localparam logic [15:0] BASE = 16'h3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_size = 1'b0;
  logic        req_sext = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  lc3b_mem_unit #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    bit          abs_time;
    int          cycle;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          accept;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  logic [7:0]  ref_bytes [0:511];
  logic [15:0] bus_words [0:255];

  int n_checks = 0;
  int n_fail = 0;
  int force_wait = -1;
  bit hold_ack = 1'b0;
  bit busy = 1'b0;
  int wait_left = 0;
  int req_cycles = 0;
  int last_ack_cycle = 0;
  bus_t cur_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic abort(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected DUT progress (cycle %0d)", name, cyc);
    summary_and_finish();
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] w);
    int off;
    off = int'(a - BASE) & ~1;
    ref_bytes[off]     = w[7:0];
    ref_bytes[off + 1] = w[15:8];
    bus_words[off / 2] = w;
  endtask

  // Waits for req_ready (driving junk meanwhile), presents the request and records expectations.
  task automatic issue(input logic wr, input logic sz, input logic sx,
                       input logic [15:0] a, input logic [15:0] wd, input bit expect_timeout);
    int   n;
    int   off;
    rsp_t r;
    bus_t b;
    logic [7:0] lb;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_size  = 1'($urandom);
      req_sext  = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      n++;
      if (n > 100) abort("req_ready_wait");
    end
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_sext  = sx;
    req_addr  = a;
    req_wdata = wd;
    off = int'(a - BASE);
    r.rdata = '0;
    r.err = 1'b0;
    r.abs_time = 1'b0;
    r.cycle = 0;
    if (sz && a[0]) begin
      r.err = 1'b1;
      r.abs_time = 1'b1;
      r.cycle = cyc + 1;
    end else begin
      b.we = wr;
      b.be = sz ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
      b.addr = {a[15:1], 1'b0};
      b.wdata = sz ? wd : {wd[7:0], wd[7:0]};
      b.accept = cyc;
      bus_q.push_back(b);
      if (expect_timeout) begin
        r.err = 1'b1;
        r.abs_time = 1'b1;
        r.cycle = cyc + 1 + MAX_WAIT;
      end else if (wr) begin
        if (sz) begin
          ref_bytes[off & ~1] = wd[7:0];
          ref_bytes[off | 1]  = wd[15:8];
        end else begin
          ref_bytes[off] = wd[7:0];
        end
      end else if (sz) begin
        r.rdata = {ref_bytes[off | 1], ref_bytes[off & ~1]};
      end else begin
        lb = ref_bytes[off];
        r.rdata = sx ? {{8{lb[7]}}, lb} : {8'h00, lb};
      end
    end
    rsp_q.push_back(r);
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (rsp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > limit) abort("drain_wait");
    end
  endtask

  // Memory-bus responder: checks bus fields every request cycle and acks after a chosen delay.
  initial begin : responder
    int idx;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (!reset) begin
        busy = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_req), 32'(0));
            continue;
          end
          cur_bus = bus_q.pop_front();
          busy = 1'b1;
          req_cycles = 0;
          wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          chk("mem_req_start_cycle", 32'(cyc), 32'(cur_bus.accept + 1));
        end
        req_cycles++;
        chk("mem_we", 32'(mem_we), 32'(cur_bus.we));
        chk("mem_be", 32'(mem_be), 32'(cur_bus.be));
        chk("mem_addr", 32'(mem_addr), 32'(cur_bus.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(cur_bus.wdata));
        if (!hold_ack && wait_left == 0) begin
          idx = int'(mem_addr - BASE) / 2;
          mem_ack = 1'b1;
          if (mem_we) begin
            if (mem_be[0]) bus_words[idx][7:0]  = mem_wdata[7:0];
            if (mem_be[1]) bus_words[idx][15:8] = mem_wdata[15:8];
          end else begin
            mem_rdata = bus_words[idx];
          end
          last_ack_cycle = cyc;
          busy = 1'b0;
        end else if (wait_left > 0) begin
          wait_left--;
        end
      end else if (busy) begin
        // Request withdrawn without an ack: only legal as a timeout.
        chk("timeout_req_cycles", 32'(req_cycles), 32'(MAX_WAIT));
        busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'(0));
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.abs_time ? e.cycle : last_ack_cycle + 1));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
    chk({tag, "_mem_req"}, 32'(mem_req), 32'(0));
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    chk({tag, "_mem_be"}, 32'(mem_be), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
  endtask

  initial begin : watchdog
    #600000;
    abort("global_watchdog");
  end

  initial begin : stimulus
    logic        wr, sz, sx;
    logic [15:0] a, wd;
    int          n;
    for (int i = 0; i < 256; i++) preload(BASE + 16'(2 * i), 16'($urandom));

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Word load with two wait cycles.
    preload(16'h3000, 16'h1234);
    force_wait = 2;
    issue(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0);
    release_req();
    drain(50);
    force_wait = 0;

    // Byte loads from the upper lane, sign- and zero-extended.
    preload(16'h3000, 16'h80FF);
    issue(1'b0, 1'b0, 1'b1, 16'h3001, 16'h0000, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 1'b0);
    release_req();
    drain(50);

    // Byte store to odd address, then read back as a word.
    issue(1'b1, 1'b0, 1'b0, 16'h3003, 16'h00AB, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 16'h3002, 16'h0000, 1'b0);
    release_req();
    drain(50);

    // Misaligned word load.
    issue(1'b0, 1'b1, 1'b0, 16'h3001, 16'h0000, 1'b0);
    release_req();
    drain(50);

    // Reset while the bus request is outstanding.
    hold_ack = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 16'h3020, 16'h0000, 1'b0);
    release_req();
    n = 0;
    while (!busy) begin
      @(negedge clk);
      n++;
      if (n > 20) abort("bus_start_wait");
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    rsp_q.delete();
    bus_q.delete();
    hold_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b0, 1'b1, 1'b0, 16'h3020, 16'h0000, 1'b0);
    release_req();
    drain(50);

`ifdef MEM_UNIT_TIMEOUT_EN
    hold_ack = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 16'h3010, 16'h0000, 1'b1);
    release_req();
    drain(60);
    hold_ack = 1'b0;
`endif

    // Randomized traffic with random bus latency and idle gaps.
    force_wait = -1;
    for (int t = 0; t < 300; t++) begin
      wr = ($urandom_range(0, 2) == 0);
      sz = 1'($urandom);
      sx = 1'($urandom);
      a  = BASE + 16'($urandom_range(0, 511));
      wd = 16'($urandom);
      issue(wr, sz, sx, a, wd, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        release_req();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    release_req();
    drain(100);
    repeat (3) @(negedge clk);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'(0));
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'(0));
    summary_and_finish();
  end

endmodule
